// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the unified SRAM port arbiter.
// Owner encoding, tag layout and parameter range checks.
package sram_arb_pkg;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  typedef struct packed {
    logic vld;
    logic own;
  } arb_tag_t;

  localparam int unsigned TAG_W    = 2;
  localparam int unsigned STREAK_W = 4;

  function automatic bit lat_ok(int unsigned lat);
    return (lat >= 1) && (lat <= 4);
  endfunction

  function automatic bit streak_ok(int unsigned smax);
    return (smax >= 1) && (smax <= 15);
  endfunction

  function automatic bit cfg_ok(int unsigned lat,
                                int unsigned smax);
    return lat_ok(lat) && streak_ok(smax);
  endfunction

endpackage

// File: rtl/arb_tag_pipe.sv
// Fixed-depth shift register of {valid, owner} tags.
// Synchronous clear drops every in-flight response.
module arb_tag_pipe
  import sram_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic     clk,
  input  logic     resetn,
  input  arb_tag_t tag_i,
  output logic     vld_o,
  output logic     own_o
);

  arb_tag_t [DEPTH-1:0] stage_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign vld_o = stage_q[DEPTH-1].vld;
  assign own_o = stage_q[DEPTH-1].own;

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbitrates the single SRAM port between fetch and load/store.
// Data wins unless a waiting fetch has seen STREAK_MAX data grants.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STREAK_MAX = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  if (!cfg_ok(MEM_LAT, STREAK_MAX)) begin : g_bad_cfg
    $error("sram_port_arbiter: MEM_LAT/STREAK_MAX out of range");
  end

  localparam logic [STREAK_W-1:0] SMAX = STREAK_W'(STREAK_MAX);

  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                gnt_data, gnt_inst, any_gnt;
  logic                tag_vld, tag_own;
  arb_tag_t            tag_in;

  always_comb begin
    gnt_data = resetn & data_req
             & ~(inst_req & (streak_q == SMAX));
    gnt_inst = resetn & inst_req & ~gnt_data;
  end

  assign any_gnt      = gnt_data | gnt_inst;
  assign inst_addr_ok = gnt_inst;
  assign data_addr_ok = gnt_data;
  assign mem_en       = any_gnt;
  assign mem_we       = (gnt_data & data_wr) ? data_wstrb : 4'b0000;
  assign mem_wdata    = resetn ? data_wdata : '0;

  always_comb begin
    mem_addr = '0;
    unique case (1'b1)
      gnt_data: mem_addr = data_addr;
      gnt_inst: mem_addr = inst_addr;
      default:  mem_addr = '0;
    endcase
  end

  // Counts data grants that overtook a waiting fetch.
  always_comb begin
    streak_d = streak_q;
    if (!inst_req || gnt_inst) begin
      streak_d = '0;
    end else if (gnt_data && (streak_q != SMAX)) begin
      streak_d = streak_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

  assign tag_in.vld = any_gnt;
  assign tag_in.own = gnt_data ? OWN_DATA : OWN_INST;

  arb_tag_pipe #(
    .DEPTH (MEM_LAT)
  ) u_tag_pipe (
    .clk    (clk),
    .resetn (resetn),
    .tag_i  (tag_in),
    .vld_o  (tag_vld),
    .own_o  (tag_own)
  );

  assign inst_data_ok = resetn & tag_vld & (tag_own == OWN_INST);
  assign data_data_ok = resetn & tag_vld & (tag_own == OWN_DATA);
  assign inst_rdata   = resetn ? mem_rdata : '0;
  assign data_rdata   = resetn ? mem_rdata : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Three arbiters (MEM_LAT 1,2,3) share one stimulus stream.
// A rule-level model predicts grants and response cycles.
module tb_sram_port_arbiter;

  localparam int SM   = 4;
  localparam int NCYC = 512;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, data_req, data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] inst_addr, data_addr, data_wdata, mem_rdata;

  logic [2:0]        iaok, daok, idok, ddok, men;
  logic [2:0][3:0]   mwe;
  logic [2:0][31:0]  maddr, mwd, ird, drd;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int wait_n = 0;
  bit ev [3][NCYC];
  bit eo [3][NCYC];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sram_port_arbiter #(
      .MEM_LAT    (g + 1),
      .STREAK_MAX (SM)
    ) u_dut (
      .clk          (clk),
      .resetn       (resetn),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_addr_ok (iaok[g]),
      .inst_data_ok (idok[g]),
      .inst_rdata   (ird[g]),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_wstrb   (data_wstrb),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_addr_ok (daok[g]),
      .data_data_ok (ddok[g]),
      .data_rdata   (drd[g]),
      .mem_en       (men[g]),
      .mem_we       (mwe[g]),
      .mem_addr     (maddr[g]),
      .mem_wdata    (mwd[g]),
      .mem_rdata    (mem_rdata)
    );
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h want %h",
               nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: priority rule, fetch-wait bound, fixed-latency responses.
  always @(negedge clk) begin
    bit eg_d, eg_i, ed;
    if (cyc > 0) begin
      if (!resetn) begin
        for (int k = 0; k < 3; k++) begin
          chk($sformatf("rst_ctl%0d", k),
              {iaok[k], daok[k], idok[k], ddok[k],
               men[k], mwe[k]}, 32'h0);
          chk($sformatf("rst_bus%0d", k),
              maddr[k] | mwd[k] | ird[k] | drd[k], 32'h0);
          for (int c = 0; c < NCYC; c++) begin
            ev[k][c] = 1'b0;
          end
        end
        wait_n = 0;
      end else begin
        eg_d = data_req && !(inst_req && wait_n >= SM);
        eg_i = !eg_d && inst_req;
        for (int k = 0; k < 3; k++) begin
          chk($sformatf("data_aok%0d", k), daok[k], eg_d);
          chk($sformatf("inst_aok%0d", k), iaok[k], eg_i);
          chk($sformatf("mem_en%0d", k), men[k], eg_d | eg_i);
          chk($sformatf("mem_we%0d", k), mwe[k],
              (eg_d && data_wr) ? data_wstrb : 4'h0);
          if (eg_d) begin
            chk($sformatf("maddr_d%0d", k), maddr[k], data_addr);
            chk($sformatf("mwdata%0d", k), mwd[k], data_wdata);
          end else if (eg_i) begin
            chk($sformatf("maddr_i%0d", k), maddr[k], inst_addr);
          end
          ed = ev[k][cyc];
          chk($sformatf("inst_dok%0d", k), idok[k], ed && !eo[k][cyc]);
          chk($sformatf("data_dok%0d", k), ddok[k], ed && eo[k][cyc]);
          if (ed) begin
            chk($sformatf("rdata%0d", k),
                eo[k][cyc] ? drd[k] : ird[k], mem_rdata);
          end
          if ((eg_d || eg_i) && (cyc + k + 1 < NCYC)) begin
            ev[k][cyc+k+1] = 1'b1;
            eo[k][cyc+k+1] = eg_d;
          end
        end
        if (!inst_req || eg_i) wait_n = 0;
        else if (eg_d && wait_n < SM) wait_n++;
      end
    end
  end

  initial begin
    resetn     = 1'b0;
    inst_req   = 1'b1;
    data_req   = 1'b1;
    data_wr    = 1'b1;
    data_wstrb = 4'hF;
    inst_addr  = 32'h0000_0040;
    data_addr  = 32'h0000_0080;
    data_wdata = 32'h5555_AAAA;
    mem_rdata  = 32'h1234_5678;

    // reset with requests active: everything gated off
    repeat (3) tick();
    #1;
    chk("rst_mem_en", men[0], 1'b0);
    chk("rst_daok", daok[0], 1'b0);
    chk("rst_iaok", iaok[0], 1'b0);
    chk("rst_maddr", maddr[0], 32'h0);
    chk("rst_rdata", drd[0], 32'h0);

    tick();
    resetn   = 1'b1;
    inst_req = 1'b0;
    data_req = 1'b0;
    data_wr  = 1'b0;
    repeat (10) begin
      tick();
      #1;
      chk("idle_en", men[0], 1'b0);
      chk("idle_dok", idok[0] | ddok[0], 1'b0);
    end

    // single load, MEM_LAT=1
    tick();
    data_req  = 1'b1;
    data_wr   = 1'b0;
    data_addr = 32'h0000_0100;
    #1;
    chk("ld_aok", daok[0], 1'b1);
    chk("ld_en", men[0], 1'b1);
    chk("ld_we", mwe[0], 4'h0);
    chk("ld_addr", maddr[0], 32'h0000_0100);
    tick();
    data_req  = 1'b0;
    mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("ld_dok", ddok[0], 1'b1);
    chk("ld_rdata", drd[0], 32'hDEAD_BEEF);
    chk("ld_no_iok", idok[0], 1'b0);

    // simultaneous store + fetch
    tick();
    inst_req   = 1'b1;
    inst_addr  = 32'h0000_0200;
    data_req   = 1'b1;
    data_wr    = 1'b1;
    data_wstrb = 4'b0011;
    data_addr  = 32'h0000_0300;
    data_wdata = 32'h1234_5678;
    #1;
    chk("sim_daok", daok[0], 1'b1);
    chk("sim_iaok", iaok[0], 1'b0);
    chk("sim_we", mwe[0], 4'b0011);
    tick();
    data_req = 1'b0;
    data_wr  = 1'b0;
    #1;
    chk("sim_iaok2", iaok[0], 1'b1);
    chk("sim_iaddr", maddr[0], 32'h0000_0200);
    chk("sim_st_ack", ddok[0], 1'b1);
    tick();
    inst_req  = 1'b0;
    mem_rdata = 32'hCAFE_0001;
    #1;
    chk("sim_iok", idok[0], 1'b1);
    chk("sim_no_dok", ddok[0], 1'b0);
    chk("sim_irdata", ird[0], 32'hCAFE_0001);

    // starvation bound: D,D,D,D,I repeating
    tick();
    inst_req  = 1'b1;
    data_req  = 1'b1;
    inst_addr = 32'h0000_0600;
    data_addr = 32'h0000_0700;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) tick();
      #1;
      chk($sformatf("starve_i%0d", i), iaok[0], (i % 5) == 4);
      chk($sformatf("starve_d%0d", i), daok[0], (i % 5) != 4);
    end
    tick();
    inst_req = 1'b0;
    data_req = 1'b0;
    repeat (4) tick();

    // back-to-back fetches, MEM_LAT=3
    inst_req  = 1'b1;
    inst_addr = 32'h0000_0400;
    #1;
    chk("pipe_aok", iaok[2], 1'b1);
    tick();
    inst_addr = 32'h0000_0404;
    tick();
    inst_addr = 32'h0000_0408;
    #1;
    chk("pipe_t2", idok[2], 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      inst_req  = 1'b0;
      mem_rdata = 32'hA0 + i;
      #1;
      chk($sformatf("pipe_t%0d", i + 3), idok[2], 1'b1);
      chk($sformatf("pipe_rd%0d", i), ird[2], 32'hA0 + i);
    end
    tick();
    #1;
    chk("pipe_t6", idok[2], 1'b0);

    // reset while a MEM_LAT=2 load is in flight
    tick();
    data_req  = 1'b1;
    data_wr   = 1'b0;
    data_addr = 32'h0000_0500;
    #1;
    chk("mid_aok", daok[1], 1'b1);
    tick();
    data_req = 1'b0;
    resetn   = 1'b0;
    #1;
    chk("mid_rst_en", men[1], 1'b0);
    chk("mid_rst_dok", ddok[1], 1'b0);
    tick();
    #1;
    chk("mid_due_dok", ddok[1], 1'b0);
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      chk($sformatf("mid_after%0d", i), ddok[1] | ddok[0], 1'b0);
    end

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares the single unified SRAM port between the IF-stage instruction-fetch requester and the EX-stage load/store requester. Each requester uses a req/addr_ok/data_ok handshake. The arbiter grants at most one request per cycle and drives the SRAM. It returns each response to its owner after a fixed memory latency. Data accesses have priority; a bounded-streak counter guarantees fetch forward progress.

## Interface
- `MEM_LAT`, default 1: SRAM read latency in cycles, legal range 1..4.
- `STREAK_MAX`, default 4: maximum consecutive data grants while a fetch is waiting, legal range 1..15.

Clock and reset:
- `clk` in 1: clock.
- `resetn` in 1: reset, synchronous, active-low.

Instruction requester:
- `inst_req` in 1: fetch request.
- `inst_addr` in 32: fetch address, word-aligned.
- `inst_addr_ok` out 1: fetch request accepted this cycle.
- `inst_data_ok` out 1: fetch response valid this cycle.
- `inst_rdata` out 32: fetch data.

Data requester:
- `data_req` in 1: load/store request.
- `data_wr` in 1: 1 = store.
- `data_wstrb` in 4: byte enables for a store.
- `data_addr` in 32: access address.
- `data_wdata` in 32: store data.
- `data_addr_ok` out 1: request accepted this cycle.
- `data_data_ok` out 1: response valid this cycle, for loads and stores.
- `data_rdata` out 32: load data.

Memory port:
- `mem_en` out 1: SRAM access this cycle.
- `mem_we` out 4: byte write enables.
- `mem_addr` out 32: SRAM address.
- `mem_wdata` out 32: SRAM write data.
- `mem_rdata` in 32: read data, valid `MEM_LAT` cycles after `mem_en`.

## Operation
- **Grant, per cycle, combinational from the inputs and `streak_cnt`:**
  - If `data_req` and not (`inst_req` and `streak_cnt == STREAK_MAX`), grant data.
  - Else if `inst_req`, grant inst.
  - Else no grant.
- **Granted requester:** its `*_addr_ok` is 1 this cycle and the other requester's is 0.
- **Memory drive on a grant:** `mem_en` = 1.
  - `mem_addr` is the winner's address.
  - `mem_we` is `data_wstrb` for a data store, else 4'b0000.
  - `mem_wdata` is `data_wdata`.
  - With no grant, `mem_en` = 0 and `mem_we` = 0.
- **Streak counter (4 bits):**
  - Increments on a data grant while `inst_req` = 1.
  - Clears on an inst grant or whenever `inst_req` = 0.
  - Saturates at `STREAK_MAX`.
- **Tag pipeline:** `MEM_LAT` stages of {valid, owner}.
  - A grant enters stage 0; the tags shift every cycle.
  - At the last stage, a valid tag asserts `<owner>_data_ok` for exactly one cycle.
  - Stores also get `data_data_ok` as a write acknowledge.
- **Read data:** `inst_rdata` and `data_rdata` both carry `mem_rdata`. They are meaningful only when the matching `*_data_ok` is 1.
- **Back-pressure:** requesters never stall responses. `data_ok` has no ready; a requester must accept it.
- **Issue rate:** a new grant is allowed every cycle, so up to `MEM_LAT` transactions are in flight. Responses return in grant order.
- **Simultaneous events:**
  - A grant and a response for the same requester in the same cycle are both legal and independent.
  - `req` dropped without `addr_ok` has no effect.
- **Reset mid-operation:** all tag stages are invalidated and `streak_cnt` is cleared. In-flight responses are discarded; no `data_ok` is asserted for pre-reset grants.

## Timing
- **Reset values:**
  - `inst_addr_ok`, `data_addr_ok`, `inst_data_ok`, `data_data_ok`, `mem_en`: 0.
  - `mem_we`: 0.
  - `mem_addr`, `mem_wdata`, rdata outputs: 0 while in reset (gated).
- **addr_ok latency:** 0 cycles; same cycle as `req`, combinational.
- **data_ok latency:** a grant in cycle T gives `data_ok` in cycle T+`MEM_LAT`. `mem_rdata` is sampled in that same cycle.
- **Outputs:** `data_ok` outputs are registered; `addr_ok` and `mem_*` are combinational from the inputs.
- **Fetch wait bound:** with `data_req` held high and `inst_req` high, inst is granted within `STREAK_MAX`+1 cycles.

## Structure
- **Shared package `sram_arb_pkg`:**
  - Owner constants `OWN_INST` = 1'b0 and `OWN_DATA` = 1'b1.
  - Tag width (2: valid + owner).
  - Legal-range checks for `MEM_LAT` and `STREAK_MAX`.
- **Sub-module `arb_tag_pipe`:** parameterised `MEM_LAT`-deep shift register of tags with synchronous clear. It outputs the last-stage valid and owner.
- **Top:** the grant logic, streak counter and output muxing stay in the top.

## Test plan
- **Single load, `MEM_LAT`=1:** `data_req` load at addr 0x100, with `mem_rdata` = 0xDEADBEEF one cycle later. Expect `data_addr_ok` in cycle T, `mem_en`=1, `mem_we`=0, then `data_data_ok`=1 and `data_rdata`=0xDEADBEEF at T+1, and no `inst_data_ok`.
- **Simultaneous requests:** `inst_req` and a `data_req` store (wstrb 4'b0011) in the same cycle. Expect data granted, `mem_we`=4'b0011 and `inst_addr_ok`=0. Inst is granted the next cycle; `data_data_ok` then `inst_data_ok` follow on consecutive cycles.
- **Starvation bound, `STREAK_MAX`=4:** `data_req` and `inst_req` held high. Expect grant pattern D,D,D,D,I repeating, with `streak_cnt` clearing after each I.
- **Back-to-back pipelining, `MEM_LAT`=3:** 3 inst fetches granted in consecutive cycles. Expect `inst_data_ok` on cycles T+3, T+4, T+5 in order.
- **Reset mid-flight, `MEM_LAT`=2:** grant a load, then assert `resetn`=0 the next cycle. Expect no `data_data_ok` ever, and all outputs 0 during reset.
- **Idle cycles:** with no requests, `mem_en`=0, no `addr_ok` and no `data_ok` for 10 cycles.
